// File: rtl/register_adder_multiply_pkg.sv
// rtl/register_adder_multiply_pkg.sv - shared widths and word types for the MAC datapath
//
// Package mac_pkg
//   MAC_IN_W  : default signed operand width
//   MAC_OUT_W : default accumulator width (>= 2*MAC_IN_W)
//   prod_t    : full-precision product word
//   acc_t     : accumulator word
package mac_pkg;

  localparam int MAC_IN_W  = 16;
  localparam int MAC_OUT_W = 38;

  typedef logic signed [2*MAC_IN_W-1:0] prod_t;
  typedef logic signed [MAC_OUT_W-1:0]  acc_t;

endpackage

// File: rtl/register_adder_multiply_pipe_reg.sv
// rtl/register_adder_multiply_pipe_reg.sv - pipeline register with async reset and sync clear
//
// Module pipe_reg
//   clk : rising-edge clock
//   rst : asynchronous active-low reset, clears q
//   clr : synchronous clear, takes priority over d
//   d   : next-state data
//   q   : registered data
module pipe_reg #(
  parameter int Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [Width-1:0] d,
  output logic [Width-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/register_adder_multiply.sv
// rtl/register_adder_multiply.sv - signed multiply-accumulate core of the FIR datapath
//
// Module register_adder_multiply
//   clk    : rising-edge clock
//   rst    : asynchronous active-low reset of both registers
//   a      : signed sample operand
//   b      : signed coefficient operand
//   flush  : synchronous clear of product register and accumulator
//   freeze : synchronous clear of product register only (accumulator holds a cycle later)
//   dout   : signed accumulator value, straight from the accumulator register
//
// Build option: define MAC_SAT_EN to saturate the accumulator add to the
// signed OutputWidth range; otherwise the add wraps.
module register_adder_multiply
  import mac_pkg::*;
#(
  parameter int InputWidth  = MAC_IN_W,
  parameter int OutputWidth = MAC_OUT_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic signed [InputWidth-1:0]  a,
  input  logic signed [InputWidth-1:0]  b,
  input  logic                          flush,
  input  logic                          freeze,
  output logic signed [OutputWidth-1:0] dout
);

  localparam int ProdWidth = 2 * InputWidth;

  logic signed [ProdWidth-1:0]   prod;
  logic signed [ProdWidth-1:0]   prod_q;
  logic signed [OutputWidth-1:0] prod_ext;
  logic signed [OutputWidth-1:0] acc_q;
  logic signed [OutputWidth-1:0] sum;
  logic signed [OutputWidth-1:0] acc_d;

  // Widen both operands first so the full-precision product is kept.
  assign prod = ProdWidth'(a) * ProdWidth'(b);

  pipe_reg #(.Width(ProdWidth)) u_prod_reg (
    .clk (clk),
    .rst (rst),
    .clr (flush | freeze),
    .d   (prod),
    .q   (prod_q)
  );

  // Size cast of a signed value replicates its MSB.
  assign prod_ext = OutputWidth'(prod_q);
  assign sum      = acc_q + prod_ext;

`ifdef MAC_SAT_EN
  localparam logic [OutputWidth-1:0] AccMax = {1'b0, {(OutputWidth-1){1'b1}}};
  localparam logic [OutputWidth-1:0] AccMin = {1'b1, {(OutputWidth-1){1'b0}}};

  logic ovf;

  // Overflow only when both addends share a sign and the sum's sign differs.
  assign ovf = (acc_q[OutputWidth-1] == prod_ext[OutputWidth-1]) &&
               (sum[OutputWidth-1] != acc_q[OutputWidth-1]);

  always_comb begin
    acc_d = sum;
    if (ovf) begin
      acc_d = acc_q[OutputWidth-1] ? AccMin : AccMax;
    end
  end
`else
  assign acc_d = sum;
`endif

  pipe_reg #(.Width(OutputWidth)) u_acc_reg (
    .clk (clk),
    .rst (rst),
    .clr (flush),
    .d   (acc_d),
    .q   (acc_q)
  );

  assign dout = acc_q;

endmodule

// File: tb/tb_register_adder_multiply.sv
// tb/tb_register_adder_multiply.sv - directed self-checking bench for register_adder_multiply
module tb_register_adder_multiply;

  logic               clk;
  logic               rst;
  logic signed [15:0] a;
  logic signed [15:0] b;
  logic               flush;
  logic               freeze;
  logic signed [37:0] dout;

  int checks;
  int errors;

  register_adder_multiply #(.InputWidth(16), .OutputWidth(38)) dut (
    .clk    (clk),
    .rst    (rst),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .freeze (freeze),
    .dout   (dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_acc();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    logic [37:0] exp [3];
    exp[0] = 38'd0;
    exp[1] = 38'd12;
    exp[2] = 38'd24;
    rst = 1'b0; flush = 1'b0; freeze = 1'b0; a = 16'sd3; b = 16'sd4;
    step();
    step();
    checks++;
    if (dout !== 38'd0) begin
      errors++;
      $display("FAIL reset_hold got %0h exp 0", dout);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (dout !== exp[i]) begin
        errors++;
        $display("FAIL reset_ramp[%0d] got %0h exp %0h", i, dout, exp[i]);
      end
    end
  endtask

  task automatic test_negative();
    a = 16'sd0; b = 16'sd0;
    clear_acc();
    a = -16'sd2; b = 16'sd5;
    step();
    checks++;
    if (dout !== 38'd0) begin
      errors++;
      $display("FAIL neg_latency got %0h exp 0", dout);
    end
    a = 16'sd0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (dout !== 38'h3F_FFFF_FFF6) begin
        errors++;
        $display("FAIL neg_value[%0d] got %0h exp 3ffffffff6", i, dout);
      end
    end
  endtask

  task automatic test_freeze();
    logic [37:0] exp [8];
    logic        frz [8];
    exp[0] = 38'd0;  frz[0] = 1'b0;
    exp[1] = 38'd12; frz[1] = 1'b0;
    exp[2] = 38'd24; frz[2] = 1'b0;
    exp[3] = 38'd36; frz[3] = 1'b1;
    exp[4] = 38'd36; frz[4] = 1'b1;
    exp[5] = 38'd36; frz[5] = 1'b1;
    exp[6] = 38'd36; frz[6] = 1'b0;
    exp[7] = 38'd48; frz[7] = 1'b0;
    clear_acc();
    a = 16'sd3; b = 16'sd4;
    for (int i = 0; i < 8; i++) begin
      freeze = frz[i];
      step();
      checks++;
      if (dout !== exp[i]) begin
        errors++;
        $display("FAIL freeze[%0d] got %0h exp %0h", i, dout, exp[i]);
      end
    end
    freeze = 1'b0;
  endtask

  task automatic test_flush();
    logic [37:0] exp [4];
    exp[0] = 38'd0;
    exp[1] = 38'd0;
    exp[2] = 38'd5;
    exp[3] = 38'd10;
    clear_acc();
    a = 16'sd3; b = 16'sd4;
    step();
    step();
    step();
    checks++;
    if (dout !== 38'd24) begin
      errors++;
      $display("FAIL flush_pre got %0h exp 18", dout);
    end
    a = 16'sd5; b = 16'sd1;
    flush = 1'b1;
    freeze = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      flush = 1'b0;
      freeze = 1'b0;
      checks++;
      if (dout !== exp[i]) begin
        errors++;
        $display("FAIL flush[%0d] got %0h exp %0h", i, dout, exp[i]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [37:0] exp_end;
`ifdef MAC_SAT_EN
    exp_end = 38'h1F_FFFF_FFFF;
`else
    exp_end = 38'h20_0000_0000;
`endif
    a = -16'sd32768; b = -16'sd32768;
    clear_acc();
    for (int i = 0; i < 128; i++) step();
    checks++;
    if (dout !== 38'h1F_C000_0000) begin
      errors++;
      $display("FAIL ovf_127 got %0h exp 1fc0000000", dout);
    end
    a = 16'sd0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (dout !== exp_end) begin
        errors++;
        $display("FAIL ovf_end[%0d] got %0h exp %0h", i, dout, exp_end);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [37:0] exp [3];
    exp[0] = 38'd0;
    exp[1] = 38'd12;
    exp[2] = 38'd24;
    clear_acc();
    a = 16'sd3; b = 16'sd4;
    step();
    step();
    step();
    checks++;
    if (dout !== 38'd24) begin
      errors++;
      $display("FAIL async_pre got %0h exp 18", dout);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (dout !== 38'd0) begin
      errors++;
      $display("FAIL async_clear got %0h exp 0", dout);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (dout !== exp[i]) begin
        errors++;
        $display("FAIL async_ramp[%0d] got %0h exp %0h", i, dout, exp[i]);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_negative();
    test_freeze();
    test_flush();
    test_overflow();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/register_adder_multiply.md
# register_adder_multiply

Signed multiply-accumulate (MAC) unit: a combinational multiplier feeds a pipeline register, whose output is sign-extended and added into an accumulator register. It is the arithmetic core of the FIR datapath. A tap-sequencing controller presents one sample/coefficient pair per cycle and uses `flush` and `freeze` to frame each output sample.

## Interface
- `InputWidth`, default 16: width of each signed operand.
- `OutputWidth`, default 38: accumulator width; must be ≥ 2*`InputWidth`.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `a` input `InputWidth`: signed two's-complement sample operand.
- `b` input `InputWidth`: signed two's-complement coefficient operand.
- `flush` input 1: synchronous clear of the product register and the accumulator.
- `freeze` input 1: synchronous clear of the product register only.
- `dout` output `OutputWidth`: signed accumulator value, driven directly from the accumulator register.

## Operation
- Product: `prod = a * b`, signed, full 2*`InputWidth` bits, no truncation.
- Product register (`prod_q`, 2*`InputWidth` bits), next-state priority:
  - `rst` low gives 0.
  - Otherwise `flush` or `freeze` gives 0.
  - Otherwise `prod`.
- Sign extension: `prod_q` is sign-extended to `OutputWidth` bits (replicate its MSB).
- Accumulator (`acc_q`, `OutputWidth` bits), next-state priority:
  - `rst` low gives 0.
  - Otherwise `flush` gives 0.
  - Otherwise `acc_q + sext(prod_q)`.
- Overflow: addition wraps modulo 2^`OutputWidth` unless `MAC_SAT_EN` is defined (see Configuration).
- `freeze` does not clear `acc_q`. It only inserts a zero product, so the accumulator holds one cycle later.
- `flush` and `freeze` together behave as `flush`.
- Both registers load every cycle; there is no load enable.

## Timing
- Reset: `dout` = 0 while `rst` is low. Clear is asynchronous; release is synchronous to `clk`.
- Latency: an operand pair sampled at edge N is in `prod_q` after edge N. It is added into `dout` at edge N+1.
- `freeze` asserted at edge N:
  - `prod_q` = 0 after edge N.
  - The product captured at edge N-1 is still added at edge N.
  - `dout` holds from edge N+1 onward for as long as `freeze` stays high.
- `flush` at edge N: `dout` = 0 after edge N.
  - The product sampled at edge N is discarded.
  - Accumulation restarts with operands sampled at edge N+1, which reach `dout` after edge N+2.
- Reset mid-operation: both registers clear immediately and any in-flight product is lost.

## Configuration
- `MAC_SAT_EN` defined:
  - The accumulator add saturates to the signed `OutputWidth` range: max 2^(`OutputWidth`-1)-1, min -2^(`OutputWidth`-1).
  - Overflow is detected from the operand sign bits and the sum sign bit.
- `MAC_SAT_EN` undefined: plain wrap-around add. No saturation logic is present.

## Structure
- Shared package `mac_pkg`:
  - Default width constants `MAC_IN_W` = 16 and `MAC_OUT_W` = 38.
  - Typedefs for the product word (2*`MAC_IN_W` bits) and the accumulator word (`MAC_OUT_W` bits).
- One sub-module, `pipe_reg`:
  - Parameterised width.
  - Asynchronous active-low reset plus synchronous clear.
  - Instantiated twice: once for `prod_q`, once for `acc_q`.
- The multiplier, sign extension and adder are inline combinational logic.

## Test plan
- Reset, then `a`=3, `b`=4 held with `flush`/`freeze` low → `dout` = 0 after edge 1, 12 after edge 2, 24 after edge 3.
- Negatives: `a`=-2, `b`=5 for one cycle, then `a`=0 → `dout` = -10 (0x3F_FFFF_FFF6), then holds.
- `freeze` asserted for 3 cycles while `a`=3, `b`=4 streams → exactly one further +12 after `freeze` rises, then `dout` constant. Accumulation resumes one cycle after `freeze` drops.
- `flush` for one cycle during accumulation → `dout` = 0 after that edge. Next value = first post-flush product; the pre-flush in-flight product is dropped.
- `a`=`b`=-32768 for 128 cycles:
  - Without `MAC_SAT_EN`: `dout` wraps to -2^37.
  - With `MAC_SAT_EN`: `dout` sticks at 2^37-1.
- `rst` pulsed low asynchronously mid-accumulation → `dout` = 0 immediately, without a clock edge. After release, restarts as in the first test.
